// File: rtl/branch_target_buffer_if.sv
// Branch target buffer interface.
// Carries the fetch-stage prediction query and the execute-stage
// resolved-branch update, all in one bundle.
//   master : fetch/execute side; drives stall, lookupPc and the update
//            fields, and receives the registered prediction.
//   slave  : the branch target buffer itself.
// Signals:
//   stall                  fetch stall, holds the registered lookup result
//   lookupPc               fetch next PC, sampled at posedge
//   btbHit                 registered entry valid and tag matched
//   btbPredictedPc         stored target on hit, else 0
//   isBranchTakenPredicted hit and counter MSB set
//   updateValid            resolved-branch update strobe
//   updatePc               PC of the resolved branch
//   updateTaken            actual direction
//   updateIsJump           unconditional branch (JAL/JALR)
//   updateTarget           actual target
interface branch_target_buffer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  stall;
  logic [ADDR_WIDTH-1:0] lookupPc;
  logic                  btbHit;
  logic [ADDR_WIDTH-1:0] btbPredictedPc;
  logic                  isBranchTakenPredicted;
  logic                  updateValid;
  logic [ADDR_WIDTH-1:0] updatePc;
  logic                  updateTaken;
  logic                  updateIsJump;
  logic [ADDR_WIDTH-1:0] updateTarget;

  modport master (
    output stall, lookupPc,
    output updateValid, updatePc, updateTaken, updateIsJump, updateTarget,
    input  btbHit, btbPredictedPc, isBranchTakenPredicted
  );

  modport slave (
    input  stall, lookupPc,
    input  updateValid, updatePc, updateTaken, updateIsJump, updateTarget,
    output btbHit, btbPredictedPc, isBranchTakenPredicted
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters per entry. Fetch presents its next PC; one clock later the
// registered hit flag, target and taken prediction are returned. Execute
// writes resolved outcomes through the update fields of the interface.
// Ports:
//   clk    clock
//   rst    synchronous reset, active-high, priority over stall and update
//   btbBus slave side of branch_target_buffer_if (query + update)
module branch_target_buffer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  btbBus
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int ENTRIES   = 1 << INDEX_WIDTH;

  // Entry storage
  logic                  valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            cnt_q    [ENTRIES];

  // Registered lookup result
  logic [TAG_WIDTH-1:0]  lookupTag_q;
  logic                  entryValid_q;
  logic [TAG_WIDTH-1:0]  entryTag_q;
  logic [ADDR_WIDTH-1:0] entryTarget_q;
  logic [1:0]            entryCnt_q;

  logic [INDEX_WIDTH-1:0] updIdx;
  logic [TAG_WIDTH-1:0]   updTag;
  logic                   updHit;
  logic                   updWrite;
  logic                   newValid_d;
  logic [TAG_WIDTH-1:0]   newTag_d;
  logic [ADDR_WIDTH-1:0]  newTarget_d;
  logic [1:0]             newCnt_d;

  logic [INDEX_WIDTH-1:0] lkIdx;
  logic [TAG_WIDTH-1:0]   lkTag;
  logic                   lkValid_d;
  logic [TAG_WIDTH-1:0]   lkEntryTag_d;
  logic [ADDR_WIDTH-1:0]  lkTarget_d;
  logic [1:0]             lkCnt_d;
  logic                   bypass;

  assign updIdx = btbBus.updatePc[INDEX_WIDTH+1:2];
  assign updTag = btbBus.updatePc[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);
  assign lkIdx  = btbBus.lookupPc[INDEX_WIDTH+1:2];
  assign lkTag  = btbBus.lookupPc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // Build the post-update image of the addressed entry. A not-taken
  // miss leaves the table untouched, so updWrite stays low.
  always_comb begin
    updWrite    = 1'b0;
    newValid_d  = valid_q[updIdx];
    newTag_d    = tag_q[updIdx];
    newTarget_d = target_q[updIdx];
    newCnt_d    = cnt_q[updIdx];
    if (btbBus.updateValid) begin
      if (updHit) begin
        updWrite = 1'b1;
        if (btbBus.updateIsJump) begin
          newCnt_d = 2'b11;
        end else if (btbBus.updateTaken) begin
          if (cnt_q[updIdx] != 2'b11) newCnt_d = cnt_q[updIdx] + 2'd1;
        end else begin
          if (cnt_q[updIdx] != 2'b00) newCnt_d = cnt_q[updIdx] - 2'd1;
        end
        if (btbBus.updateTaken) newTarget_d = btbBus.updateTarget;
      end else if (btbBus.updateTaken) begin
        updWrite    = 1'b1;
        newValid_d  = 1'b1;
        newTag_d    = updTag;
        newTarget_d = btbBus.updateTarget;
        newCnt_d    = btbBus.updateIsJump ? 2'b11 : 2'b10;
      end
    end
  end

  // Write-first bypass: a lookup to the entry being written this cycle
  // sees the post-update contents.
  always_comb begin
    bypass       = updWrite && (updIdx == lkIdx);
    lkValid_d    = bypass ? newValid_d  : valid_q[lkIdx];
    lkEntryTag_d = bypass ? newTag_d    : tag_q[lkIdx];
    lkTarget_d   = bypass ? newTarget_d : target_q[lkIdx];
    lkCnt_d      = bypass ? newCnt_d    : cnt_q[lkIdx];
  end

  // Entry table: reset invalidates everything and returns counters to
  // weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (updWrite) begin
      valid_q[updIdx]  <= newValid_d;
      tag_q[updIdx]    <= newTag_d;
      target_q[updIdx] <= newTarget_d;
      cnt_q[updIdx]    <= newCnt_d;
    end
  end

  // Lookup result register; stall freezes it so fetch sees a stable
  // prediction even if the underlying entry is rewritten meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookupTag_q   <= '0;
      entryValid_q  <= 1'b0;
      entryTag_q    <= '0;
      entryTarget_q <= '0;
      entryCnt_q    <= 2'b00;
    end else if (!btbBus.stall) begin
      lookupTag_q   <= lkTag;
      entryValid_q  <= lkValid_d;
      entryTag_q    <= lkEntryTag_d;
      entryTarget_q <= lkTarget_d;
      entryCnt_q    <= lkCnt_d;
    end
  end

  assign btbBus.btbHit                 = entryValid_q && (entryTag_q == lookupTag_q);
  assign btbBus.btbPredictedPc         = btbBus.btbHit ? entryTarget_q : '0;
  assign btbBus.isBranchTakenPredicted = btbBus.btbHit && entryCnt_q[1];

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed testbench for branch_target_buffer. Inputs change 1ns after
// a rising edge; outputs are checked 1ns after the following edge, i.e.
// they show the lookup captured at that edge.
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  branch_target_buffer_if #(.ADDR_WIDTH(32)) btbIf ();

  branch_target_buffer #(.ADDR_WIDTH(32), .INDEX_WIDTH(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .btbBus (btbIf.slave)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Set lookup and update inputs for the next edge
  task automatic applyStimulus(input logic st, input logic [31:0] lpc,
                               input logic uv, input logic [31:0] upc,
                               input logic ut, input logic uj,
                               input logic [31:0] utgt);
    btbIf.stall        = st;
    btbIf.lookupPc     = lpc;
    btbIf.updateValid  = uv;
    btbIf.updatePc     = upc;
    btbIf.updateTaken  = ut;
    btbIf.updateIsJump = uj;
    btbIf.updateTarget = utgt;
    @(posedge clk);
    #1;
  endtask

  // Compare the registered prediction against hand-computed values
  task automatic checkOutput(input string name, input logic expHit,
                             input logic [31:0] expPc, input logic expTaken);
    total++;
    assert (btbIf.btbHit === expHit) else begin
      bad++;
      $error("[TB] FAIL %s.hit observed=%0b expected=%0b", name, btbIf.btbHit, expHit);
    end
    total++;
    assert (btbIf.btbPredictedPc === expPc) else begin
      bad++;
      $error("[TB] FAIL %s.pc observed=%h expected=%h", name, btbIf.btbPredictedPc, expPc);
    end
    total++;
    assert (btbIf.isBranchTakenPredicted === expTaken) else begin
      bad++;
      $error("[TB] FAIL %s.taken observed=%0b expected=%0b", name,
             btbIf.isBranchTakenPredicted, expTaken);
    end
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    checkOutput("emptyLookup", 0, 0, 0);

    // Allocate 0x100 -> 0x200 (cnt 10); same-index lookup of 0x0 misses on tag
    applyStimulus(0, 32'h000, 1, 32'h100, 1, 0, 32'h200);
    checkOutput("aliasTagMiss", 0, 0, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    checkOutput("allocHit", 1, 32'h200, 1);

    // Not-taken updates walk the counter down and saturate at 00
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 0, 32'hdead);
    checkOutput("cnt01", 1, 32'h200, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 0, 32'hdead);
    checkOutput("cnt00", 1, 32'h200, 0);
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 0, 32'hdead);
    checkOutput("cnt00sat", 1, 32'h200, 0);

    // Jump forces 11; a further taken saturates; one not-taken gives 10
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 1, 32'h200);
    checkOutput("jumpCnt11", 1, 32'h200, 1);
    applyStimulus(0, 32'h100, 1, 32'h100, 1, 0, 32'h200);
    checkOutput("cnt11sat", 1, 32'h200, 1);
    applyStimulus(0, 32'h100, 1, 32'h100, 0, 0, 32'h200);
    checkOutput("cnt10", 1, 32'h200, 1);

    // Not-taken miss on 0x300 changes nothing
    applyStimulus(0, 32'h000, 1, 32'h300, 0, 0, 32'h900);
    applyStimulus(0, 32'h300, 0, 0, 0, 0, 0);
    checkOutput("ntMiss300", 0, 0, 0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    checkOutput("stillHit100", 1, 32'h200, 1);

    // Taken update on aliasing 0x200 evicts 0x100
    applyStimulus(0, 32'h000, 1, 32'h200, 1, 0, 32'h400);
    applyStimulus(0, 32'h100, 0, 0, 0, 0, 0);
    checkOutput("evicted100", 0, 0, 0);
    applyStimulus(0, 32'h200, 0, 0, 0, 0, 0);
    checkOutput("alias200", 1, 32'h400, 1);

    // Same-cycle update and lookup: write-first bypass
    applyStimulus(0, 32'h140, 1, 32'h140, 1, 0, 32'h500);
    checkOutput("bypass140", 1, 32'h500, 1);

    // Update on a different index does not disturb the lookup
    applyStimulus(0, 32'h140, 1, 32'h144, 1, 0, 32'h600);
    checkOutput("indep140", 1, 32'h500, 1);
    applyStimulus(0, 32'h144, 0, 0, 0, 0, 0);
    checkOutput("indep144", 1, 32'h600, 1);

    // Stall holds the result while lookupPc moves and the held entry changes
    applyStimulus(1, 32'h140, 1, 32'h144, 1, 0, 32'h700);
    checkOutput("stall1", 1, 32'h600, 1);
    applyStimulus(1, 32'h144, 0, 0, 0, 0, 0);
    checkOutput("stall2", 1, 32'h600, 1);
    applyStimulus(1, 32'h000, 0, 0, 0, 0, 0);
    checkOutput("stall3", 1, 32'h600, 1);
    applyStimulus(0, 32'h144, 0, 0, 0, 0, 0);
    checkOutput("unstall", 1, 32'h700, 1);

    // Reset wins over a simultaneous update and flushes every entry
    rst = 1'b1;
    applyStimulus(0, 32'h140, 1, 32'h140, 1, 1, 32'h800);
    checkOutput("midReset", 0, 0, 0);
    rst = 1'b0;
    applyStimulus(0, 32'h140, 0, 0, 0, 0, 0);
    checkOutput("flush140", 0, 0, 0);
    applyStimulus(0, 32'h144, 0, 0, 0, 0, 0);
    checkOutput("flush144", 0, 0, 0);
    applyStimulus(0, 32'h200, 0, 0, 0, 0, 0);
    checkOutput("flush200", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters. It is the responder to the fetch stage's prediction query. Fetch presents its next PC, and one clock later this block returns a hit flag, a predicted target and a taken prediction, matching the fetch stage's clock-synchronous instruction read. The execute stage writes resolved branch outcomes back through the update port.

Parameters:
ADDR_WIDTH, 32, width of PCs and targets.
INDEX_WIDTH, 6, log2 of entry count (64 entries).
Tag width is derived, not a parameter: ADDR_WIDTH - INDEX_WIDTH - 2. PC bits [1:0] are ignored everywhere.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
stall  in  1  fetch stall; holds the registered lookup result.
lookupPc  in  ADDR_WIDTH  fetch next PC (npc), sampled at posedge.
btbHit  out  1  registered entry valid and tag matched.
btbPredictedPc  out  ADDR_WIDTH  stored target on hit, else 0.
isBranchTakenPredicted  out  1  btbHit && counter[1].
updateValid  in  1  resolved-branch update strobe from execute.
updatePc  in  ADDR_WIDTH  PC of the resolved branch.
updateTaken  in  1  actual direction.
updateIsJump  in  1  unconditional (JAL/JALR).
updateTarget  in  ADDR_WIDTH  actual target.

Behaviour:
- Address split: index = pc[INDEX_WIDTH+1:2]; tag = pc[ADDR_WIDTH-1:INDEX_WIDTH+2].
- Per-entry state: valid, tag, target, cnt[1:0].
- Reset:
  - All valid = 0; all cnt = 2'b01.
  - Lookup result register cleared, so btbHit = 0, btbPredictedPc = 0, isBranchTakenPredicted = 0 in the cycle after reset.
  - rst has priority over stall and updateValid.
- Lookup (latency 1):
  - At posedge with !stall, the block registers the lookup tag and the entry read at the lookup index.
  - Outputs are combinational from that register only. No combinational path exists from lookupPc to the outputs.
  - stall = 1 holds the register, so the outputs keep their previous values even if an update changes the entry.
- Update (applied at posedge when updateValid = 1):
  - Hit (entry valid and tag equal):
    - updateIsJump: cnt = 2'b11.
    - Otherwise cnt saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00).
    - target = updateTarget when taken; unchanged when not taken.
  - Miss, updateTaken = 1: allocate or evict. valid = 1, tag and target written, cnt = 2'b11 if jump, else 2'b10.
  - Miss, updateTaken = 0: no state change.
- Same-cycle lookup and update to the same index (with !stall): the lookup register captures the post-update entry (write-first bypass). Tag comparison uses the lookup tag against the bypassed tag.
- Update and lookup to different indices are fully independent.
- Only one update per cycle. Mid-operation reset discards all entries.

Test Plan:
- Reset, then lookupPc = 0x100 -> next cycle btbHit = 0, btbPredictedPc = 0, isBranchTakenPredicted = 0.
- Update pc 0x100, taken, target 0x200, not jump; lookup 0x100 two cycles later -> btbHit = 1, btbPredictedPc = 0x200, isBranchTakenPredicted = 1 (cnt = 10).
- Three not-taken updates to 0x100 -> cnt 10->01->00->00; lookup gives btbHit = 1, isBranchTakenPredicted = 0, target still 0x200. Then jump update -> cnt = 11, predicted taken.
- Not-taken update to miss pc 0x300 -> lookup 0x300 btbHit = 0. Taken update pc 0x100 + (1<<8) (same index, 64 entries) with target 0x400 evicts the entry -> lookup 0x100 misses, aliasing PC hits with 0x400.
- Same cycle: updateValid on 0x140 taken, target 0x500 and lookupPc = 0x140 -> next cycle btbHit = 1, btbPredictedPc = 0x500.
- Hold stall = 1 for 3 cycles while lookupPc changes and an update hits the held index -> outputs unchanged. Deassert stall -> new lookup is reflected one cycle later. Assert rst with updateValid = 1 -> all entries invalid afterwards.
